shift_reg_univ: RTL

Parametrised universal shift register: DEPTH stages, each WIDTH bits wide. Supports hold, shift up, shift down, rotate and parallel load, plus a saturating fill counter. It is the general-purpose successor to the fixed 3-stage, 1-bit serial-in/serial-out register. Typical uses are serial-to-parallel and parallel-to-serial conversion, delay lines and bit-pattern rotation in the datapath.

---
 rtl/shift_reg_univ.sv | 135 +++++++++++++
 1 files changed

// File: rtl/shift_reg_univ.sv
// -----------------------------------------------------------------------------
// shift_reg_univ
//
// Universal shift register: DEPTH stages of WIDTH bits each. Supports hold,
// shift up (towards stage DEPTH-1), shift down (towards stage 0), rotate in
// either direction, and parallel load. A saturating fill counter tracks how
// many stages hold valid data.
//
// Parameters:
//   WIDTH  bits per stage (>= 1)
//   DEPTH  number of stages (>= 2)
//   CW     width of fill, derived from DEPTH (leave at default)
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   clr      synchronous clear of stages and fill; independent of en
//   en       clock enable for mode operations
//   mode     00 hold, 01 shift up, 10 shift down, 11 parallel load
//   rot      in shift modes, recirculate the end stage instead of serial input
//   sin_lo   serial input into stage 0 (shift up)
//   sin_hi   serial input into stage DEPTH-1 (shift down)
//   pin      parallel load data, stage i = pin[i*WIDTH +: WIDTH]
//   pout     all stages, stage i = pout[i*WIDTH +: WIDTH]
//   sout_hi  stage DEPTH-1
//   sout_lo  stage 0
//   fill     number of valid stages, 0..DEPTH
//   full     fill == DEPTH
//
// All outputs are taken straight from flops; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module shift_reg_univ #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 3,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   en,
    input  logic [1:0]             mode,
    input  logic                   rot,
    input  logic [WIDTH-1:0]       sin_lo,
    input  logic [WIDTH-1:0]       sin_hi,
    input  logic [WIDTH*DEPTH-1:0] pin,
    output logic [WIDTH*DEPTH-1:0] pout,
    output logic [WIDTH-1:0]       sout_hi,
    output logic [WIDTH-1:0]       sout_lo,
    output logic [CW-1:0]          fill,
    output logic                   full
);

    localparam int              TOTAL    = WIDTH * DEPTH;
    localparam logic [CW-1:0]   FILL_MAX = CW'(DEPTH);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    // All stages packed into one vector: stage i lives at [i*WIDTH +: WIDTH],
    // so a shift is a single concatenation with no per-stage indexing.
    logic [TOTAL-1:0] stage_q, stage_d;
    logic [CW-1:0]    fill_q,  fill_d;
    logic             full_q,  full_d;

    logic [WIDTH-1:0] up_in;
    logic [WIDTH-1:0] down_in;
    mode_e            mode_sel;

    assign mode_sel = mode_e'(mode);

    always_comb begin
        // Value entering the vacated end stage: the opposite end when
        // rotating, otherwise the serial input for that direction.
        up_in   = rot ? stage_q[TOTAL-1 -: WIDTH] : sin_lo;
        down_in = rot ? stage_q[WIDTH-1:0]        : sin_hi;

        stage_d = stage_q;
        fill_d  = fill_q;

        if (clr) begin
            // clr discards any concurrent mode operation.
            stage_d = '0;
            fill_d  = '0;
        end else if (en) begin
            case (mode_sel)
                MODE_HOLD: begin
                end
                MODE_UP: begin
                    stage_d = {stage_q[TOTAL-WIDTH-1:0], up_in};
                    // Rotation only moves existing entries, so it adds none.
                    if (!rot && (fill_q != FILL_MAX)) begin
                        fill_d = fill_q + CW'(1);
                    end
                end
                MODE_DOWN: begin
                    stage_d = {down_in, stage_q[TOTAL-1:WIDTH]};
                    if (!rot && (fill_q != FILL_MAX)) begin
                        fill_d = fill_q + CW'(1);
                    end
                end
                MODE_LOAD: begin
                    stage_d = pin;
                    fill_d  = FILL_MAX;
                end
            endcase
        end

        // full is registered alongside fill so it changes on the same edge.
        full_d = (fill_d == FILL_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
            fill_q  <= '0;
            full_q  <= 1'b0;
        end else begin
            stage_q <= stage_d;
            fill_q  <= fill_d;
            full_q  <= full_d;
        end
    end

    assign pout    = stage_q;
    assign sout_lo = stage_q[WIDTH-1:0];
    assign sout_hi = stage_q[TOTAL-1 -: WIDTH];
    assign fill    = fill_q;
    assign full    = full_q;

endmodule
